seven_seg_scan_ctrl: RTL and testbench

//   Time-multiplexed scan controller for a multi-digit common-anode 7-segment display.

---
 rtl/seven_seg_scan_if.sv | 25 ++
 rtl/seven_seg_scan_ctrl.sv | 165 ++++++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/seven_seg_scan_if.sv
// Signal bundle between a display-data source and the 7-segment scan controller.
// The controller-side modport drives the decoder code, anode selects and frame pulse.
interface seven_seg_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    enable;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic                    lz_blank;
    logic [3:0]              dec_bin_out;
    logic [NUM_DIGITS-1:0]   anode_n;
    logic                    frame_done;
    logic [1:0]              scan_state;

    modport master (
        output enable, load, digits_in, digit_en, lz_blank,
        input  dec_bin_out, anode_n, frame_done, scan_state
    );

    modport slave (
        input  enable, load, digits_in, digit_en, lz_blank,
        output dec_bin_out, anode_n, frame_done, scan_state
    );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display with
// inter-digit blanking, leading-zero suppression and frame-aligned double buffering.
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input logic              clk,
    input logic              rst,
    seven_seg_scan_if.slave  bus
);
    // Handshake: load is a single-cycle strobe with no back-pressure; digits_in is
    // valid in the cycle load is high. frame_done is a single-cycle strobe out.
    localparam int MAX_CNT = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
    localparam int IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DW      = 4 * NUM_DIGITS;

    localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_SHOW  = 2'd2
    } state_t;

    // With no blanking configured, a digit hands straight over to the next SHOW.
    localparam state_t GAP_STATE = (BLANK_CYCLES > 0) ? S_BLANK : S_SHOW;

    state_t          state, state_nxt;
    logic [IW-1:0]   idx, idx_nxt;
    logic [CW-1:0]   counter, cnt_nxt;
    logic [DW-1:0]   active_reg, active_nxt;
    logic [DW-1:0]   pending_reg, pending_nxt;
    logic            pending_vld, pvld_nxt;
    logic            frame_end;

    logic [NUM_DIGITS-1:0] anode_r, anode_nxt;
    logic [3:0]            dec_r, dec_nxt;
    logic                  fd_r, fd_nxt;

    logic [3:0] digit_val;
    logic       digit_on;
    logic       lead_zero;
    logic       blanked;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            idx         <= '0;
            counter     <= '0;
            active_reg  <= '0;
            pending_reg <= '0;
            pending_vld <= 1'b0;
            anode_r     <= '1;
            dec_r       <= 4'hF;
            fd_r        <= 1'b0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            counter     <= cnt_nxt;
            active_reg  <= active_nxt;
            pending_reg <= pending_nxt;
            pending_vld <= pvld_nxt;
            anode_r     <= anode_nxt;
            dec_r       <= dec_nxt;
            fd_r        <= fd_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = counter;
        frame_end = 1'b0;
        if (!bus.enable) begin
            state_nxt = S_IDLE;
            idx_nxt   = '0;
            cnt_nxt   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    state_nxt = GAP_STATE;
                    idx_nxt   = '0;
                    cnt_nxt   = '0;
                end
                S_BLANK: begin
                    if (counter == BLANK_LAST) begin
                        state_nxt = S_SHOW;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = counter + 1'b1;
                    end
                end
                S_SHOW: begin
                    if (counter == SHOW_LAST) begin
                        state_nxt = GAP_STATE;
                        cnt_nxt   = '0;
                        if (idx == IDX_LAST) begin
                            idx_nxt   = '0;
                            frame_end = 1'b1;
                        end else begin
                            idx_nxt = idx + 1'b1;
                        end
                    end else begin
                        cnt_nxt = counter + 1'b1;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    idx_nxt   = '0;
                    cnt_nxt   = '0;
                end
            endcase
        end

        // A load landing on the frame-end cycle is newer than anything pending.
        active_nxt  = active_reg;
        pending_nxt = pending_reg;
        pvld_nxt    = pending_vld;
        if (state == S_IDLE) begin
            if (bus.load) active_nxt = bus.digits_in;
        end else if (frame_end) begin
            if (bus.load)        active_nxt = bus.digits_in;
            else if (pending_vld) active_nxt = pending_reg;
            pvld_nxt = 1'b0;
        end else if (bus.load) begin
            pending_nxt = bus.digits_in;
            pvld_nxt    = 1'b1;
        end
    end

    // Outputs are computed from the next-state values so the registers reflect the
    // state being entered on the same edge.
    always_comb begin
        digit_val = 4'h0;
        digit_on  = 1'b0;
        lead_zero = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (IW'(k) == idx_nxt) begin
                digit_val = active_nxt[4*k +: 4];
                digit_on  = bus.digit_en[k];
            end
            if (IW'(k) >= idx_nxt && active_nxt[4*k +: 4] != 4'h0) lead_zero = 1'b0;
        end
        blanked = !digit_on || (bus.lz_blank && idx_nxt != '0 && lead_zero);

        anode_nxt = '1;
        dec_nxt   = 4'hF;
        fd_nxt    = frame_end;
        if (state_nxt == S_SHOW && !blanked) begin
            dec_nxt = digit_val;
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (IW'(k) == idx_nxt) anode_nxt[k] = 1'b0;
            end
        end
    end

    assign bus.anode_n     = anode_r;
    assign bus.dec_bin_out = dec_r;
    assign bus.frame_done  = fd_r;
    assign bus.scan_state  = state;
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboard bench for seven_seg_scan_ctrl (4 digits, 4-cycle SHOW, 2-cycle BLANK):
// drivers queue the expected display word per clock, a negedge monitor checks it.
module tb_seven_seg_scan_ctrl;
    localparam int ND = 4;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_SHOW  = 2'd2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seven_seg_scan_if #(.NUM_DIGITS(ND)) bus ();

    seven_seg_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (4),
        .BLANK_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Entry layout: {state[1:0], anode_n[3:0], dec[3:0], frame_done}
    logic [10:0] exp_q[$];
    logic [10:0] got_w, exp_w;
    int tests  = 0;
    int failed = 0;

    function automatic logic [10:0] pack(input logic [1:0] st, input logic [3:0] an,
                                         input logic [3:0] dec, input logic fd);
        return {st, an, dec, fd};
    endfunction

    task automatic step(input logic [10:0] e);
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    task automatic dark(input logic [1:0] st, input logic fd);
        step(pack(st, 4'hF, 4'hF, fd));
    endtask

    task automatic lit(input int d_idx, input logic [3:0] d);
        logic [3:0] an;
        an        = 4'hF;
        an[d_idx] = 1'b0;
        step(pack(ST_SHOW, an, d, 1'b0));
    endtask

    // One 24-cycle frame: per digit 2 dark BLANK cycles then 4 SHOW cycles.
    task automatic frame(input logic [15:0] v, input logic [3:0] lit_mask, input logic fd);
        for (int i = 0; i < ND; i++) begin
            dark(ST_BLANK, fd && (i == 0));
            dark(ST_BLANK, 1'b0);
            for (int c = 0; c < 4; c++) begin
                if (lit_mask[i]) lit(i, v[4*i +: 4]);
                else             step(pack(ST_SHOW, 4'hF, 4'hF, 1'b0));
            end
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_w = exp_q.pop_front();
            got_w = {bus.scan_state, bus.anode_n, bus.dec_bin_out, bus.frame_done};
            tests++;
            if (got_w !== exp_w) begin
                failed++;
                $display("FAIL scan @%0t: got st=%0d an=%b dec=%h fd=%b, expected st=%0d an=%b dec=%h fd=%b",
                         $time, got_w[10:9], got_w[8:5], got_w[4:1], got_w[0],
                         exp_w[10:9], exp_w[8:5], exp_w[4:1], exp_w[0]);
            end
        end
        tests++;
        if ($countones(~bus.anode_n) > 1) begin
            failed++;
            $display("FAIL one_anode @%0t: anode_n=%b, expected at most one low bit", $time, bus.anode_n);
        end
    end

    initial begin
        #100000;
        failed++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        rst           = 1'b1;
        bus.enable    = 1'b0;
        bus.load      = 1'b0;
        bus.digits_in = '0;
        bus.digit_en  = 4'hF;
        bus.lz_blank  = 1'b0;
        #12;
        tests++;
        if ({bus.scan_state, bus.anode_n, bus.dec_bin_out, bus.frame_done} !== pack(ST_IDLE, 4'hF, 4'hF, 1'b0)) begin
            failed++;
            $display("FAIL reset: got an=%b dec=%h fd=%b, expected an=1111 dec=f fd=0",
                     bus.anode_n, bus.dec_bin_out, bus.frame_done);
        end
        @(negedge clk);
        rst = 1'b0;

        // Load in IDLE, then scan 1234 for two frames.
        bus.load = 1'b1;
        bus.digits_in = 16'h1234;
        dark(ST_IDLE, 1'b0);
        bus.load   = 1'b0;
        bus.enable = 1'b1;
        frame(16'h1234, 4'hF, 1'b0);
        frame(16'h1234, 4'hF, 1'b1);

        // Mid-frame load at idx=1 only takes effect next frame.
        fork
            frame(16'h1234, 4'hF, 1'b1);
            begin
                repeat (8) @(posedge clk);
                #2 bus.load = 1'b1; bus.digits_in = 16'h5678;
                @(posedge clk);
                #2 bus.load = 1'b0;
            end
        join

        // Two loads in one frame: last wins.
        fork
            frame(16'h5678, 4'hF, 1'b1);
            begin
                repeat (5) @(posedge clk);
                #2 bus.load = 1'b1; bus.digits_in = 16'h9999;
                @(posedge clk);
                #2 bus.load = 1'b0;
                repeat (8) @(posedge clk);
                #2 bus.load = 1'b1; bus.digits_in = 16'h4321;
                @(posedge clk);
                #2 bus.load = 1'b0;
            end
        join

        // Pending AAAA is superseded by a load on the frame-end cycle.
        fork
            frame(16'h4321, 4'hF, 1'b1);
            begin
                repeat (10) @(posedge clk);
                #2 bus.load = 1'b1; bus.digits_in = 16'hAAAA;
                @(posedge clk);
                #2 bus.load = 1'b0;
            end
        join
        bus.load      = 1'b1;
        bus.digits_in = 16'h0070;
        bus.lz_blank  = 1'b1;

        // Leading-zero suppression: 0070 lights digits 1 and 0 only.
        fork
            frame(16'h0070, 4'b0011, 1'b1);
            begin
                @(posedge clk);
                #2 bus.load = 1'b0;
                repeat (8) @(posedge clk);
                #2 bus.load = 1'b1; bus.digits_in = 16'h0000;
                @(posedge clk);
                #2 bus.load = 1'b0;
            end
        join

        // All zeros: only digit 0 lit.
        fork
            frame(16'h0000, 4'b0001, 1'b1);
            begin
                repeat (8) @(posedge clk);
                #2 bus.load = 1'b1; bus.digits_in = 16'h4321;
                @(posedge clk);
                #2 bus.load = 1'b0;
            end
        join
        bus.lz_blank = 1'b0;
        bus.digit_en = 4'b1011;

        // Masked digit 2 stays dark; frame timing unchanged.
        frame(16'h4321, 4'b1011, 1'b1);
        frame(16'h4321, 4'b1011, 1'b1);
        bus.digit_en = 4'hF;

        // enable drop mid-SHOW, then restart from idx 0.
        dark(ST_BLANK, 1'b1);
        dark(ST_BLANK, 1'b0);
        lit(0, 4'h1);
        lit(0, 4'h1);
        bus.enable = 1'b0;
        dark(ST_IDLE, 1'b0);
        dark(ST_IDLE, 1'b0);
        bus.enable = 1'b1;
        frame(16'h4321, 4'hF, 1'b0);

        // Asynchronous reset mid-SHOW with a pending load outstanding.
        dark(ST_BLANK, 1'b1);
        dark(ST_BLANK, 1'b0);
        bus.load      = 1'b1;
        bus.digits_in = 16'h5555;
        lit(0, 4'h1);
        bus.load = 1'b0;
        lit(0, 4'h1);
        @(negedge clk);
        #1;
        rst        = 1'b1;
        bus.enable = 1'b0;
        #1;
        tests++;
        if ({bus.scan_state, bus.anode_n, bus.dec_bin_out, bus.frame_done} !== pack(ST_IDLE, 4'hF, 4'hF, 1'b0)) begin
            failed++;
            $display("FAIL async_rst: got st=%0d an=%b dec=%h fd=%b, expected st=0 an=1111 dec=f fd=0",
                     bus.scan_state, bus.anode_n, bus.dec_bin_out, bus.frame_done);
        end
        dark(ST_IDLE, 1'b0);
        dark(ST_IDLE, 1'b0);
        rst = 1'b0;
        dark(ST_IDLE, 1'b0);
        bus.enable = 1'b1;
        frame(16'h0000, 4'hF, 1'b0);
        frame(16'h0000, 4'hF, 1'b1);

        @(negedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL drain: got %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
